// File: rtl/clk_freq_monitor.sv
// Receive-side lane checker: measures period and high time of one generated-clock lane.
// Optional duty-cycle limit check enabled by defining CLK_FREQ_MONITOR_DUTY_CHECK_EN.
module clk_freq_monitor #(
    parameter int N_CLK   = 32,
    parameter int CW      = 16,
    parameter int TIMEOUT = 1024,
    localparam int SW     = (N_CLK > 1) ? $clog2(N_CLK) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SW-1:0]    mon_sel,
    input  logic [N_CLK-1:0] mon_clk,
    input  logic [CW-1:0]    per_min,
    input  logic [CW-1:0]    per_max,
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
    input  logic [CW-1:0]    hi_min,
    input  logic [CW-1:0]    hi_max,
    output logic             duty_err,
`endif
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    period,
    output logic [CW-1:0]    high_time,
    output logic             per_err,
    output logic             stuck
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEAS
    } state_t;

    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   per_min_q, per_min_d;
    logic [CW-1:0]   per_max_q, per_max_d;
    logic [2:0]      sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   hi_q, hi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   period_q, period_d;
    logic [CW-1:0]   high_time_q, high_time_d;
    logic            per_err_q, per_err_d;
    logic            stuck_q, stuck_d;
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
    logic [CW-1:0]   hi_min_q, hi_min_d;
    logic [CW-1:0]   hi_max_q, hi_max_d;
    logic            duty_err_q, duty_err_d;
`endif

    // AND-OR lane mux keeps the selected lane glitch-free relative to the others.
    logic [N_CLK-1:0] lane_hit;
    for (genvar gi = 0; gi < N_CLK; gi++) begin : g_lane
        assign lane_hit[gi] = mon_clk[gi] & (sel_q == SW'(gi));
    end

    logic lane_raw;
    logic s2;
    logic rise;
    assign lane_raw = |lane_hit;
    assign s2       = sync_q[1];
    assign rise     = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        per_min_d   = per_min_q;
        per_max_d   = per_max_q;
        sync_d      = {sync_q[1:0], lane_raw};
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        period_d    = period_q;
        high_time_d = high_time_q;
        per_err_d   = per_err_q;
        stuck_d     = stuck_q;
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
        hi_min_d    = hi_min_q;
        hi_max_d    = hi_max_q;
        duty_err_d  = duty_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d     = mon_sel;
                    per_min_d = per_min;
                    per_max_d = per_max;
                    per_err_d = 1'b0;
                    stuck_d   = 1'b0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_ARM;
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
                    hi_min_d   = hi_min;
                    hi_max_d   = hi_max;
                    duty_err_d = 1'b0;
`endif
                end
            end
            ST_ARM: begin
                if (rise) begin
                    cnt_d   = CW'(1);
                    hi_d    = CW'(s2);
                    state_d = ST_MEAS;
                end else if (cnt_q == TO_CNT) begin
                    stuck_d     = 1'b1;
                    period_d    = '0;
                    high_time_d = '0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_MEAS: begin
                // A rise coinciding with the timeout count is a valid measurement.
                if (rise) begin
                    period_d    = cnt_q;
                    high_time_d = hi_q;
                    per_err_d   = (cnt_q < per_min_q) | (cnt_q > per_max_q);
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
                    duty_err_d  = (hi_q < hi_min_q) | (hi_q > hi_max_q);
`endif
                end else if (cnt_q == TO_CNT) begin
                    stuck_d     = 1'b1;
                    period_d    = '0;
                    high_time_d = '0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (s2) begin
                        hi_d = hi_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            per_min_q   <= '0;
            per_max_q   <= '0;
            sync_q      <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            period_q    <= '0;
            high_time_q <= '0;
            per_err_q   <= 1'b0;
            stuck_q     <= 1'b0;
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
            hi_min_q    <= '0;
            hi_max_q    <= '0;
            duty_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            per_min_q   <= per_min_d;
            per_max_q   <= per_max_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            per_err_q   <= per_err_d;
            stuck_q     <= stuck_d;
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
            hi_min_q    <= hi_min_d;
            hi_max_q    <= hi_max_d;
            duty_err_q  <= duty_err_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign period    = period_q;
    assign high_time = high_time_q;
    assign per_err   = per_err_q;
    assign stuck     = stuck_q;
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
    assign duty_err  = duty_err_q;
`endif

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Bench for clk_freq_monitor: lanes are driven clk-synchronously so periods are exact.
// Expected results are queued at each start and compared when done pulses.
module tb_clk_freq_monitor;

    localparam int N_CLK   = 32;
    localparam int CW      = 16;
    localparam int TIMEOUT = 64;
    localparam int SW      = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [SW-1:0]    mon_sel;
    logic [N_CLK-1:0] mon_clk;
    logic [CW-1:0]    per_min;
    logic [CW-1:0]    per_max;
    logic             busy;
    logic             done;
    logic [CW-1:0]    period;
    logic [CW-1:0]    high_time;
    logic             per_err;
    logic             stuck;
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
    logic [CW-1:0]    hi_min;
    logic [CW-1:0]    hi_max;
    logic             duty_err;
`endif

    clk_freq_monitor #(
        .N_CLK   (N_CLK),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mon_sel   (mon_sel),
        .mon_clk   (mon_clk),
        .per_min   (per_min),
        .per_max   (per_max),
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
        .hi_min    (hi_min),
        .hi_max    (hi_max),
        .duty_err  (duty_err),
`endif
        .busy      (busy),
        .done      (done),
        .period    (period),
        .high_time (high_time),
        .per_err   (per_err),
        .stuck     (stuck)
    );

    typedef struct {
        int period;
        int high;
        int per_err;
        int stuck;
        int duty;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_done = 0;
    int   cyc    = 0;
    int   lane_per [N_CLK];
    int   lane_hi  [N_CLK];
    int   lane_c   [N_CLK];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Lane generator: low for P-H cycles then high for H cycles, starting low.
    initial begin
        mon_clk = '0;
        for (int i = 0; i < N_CLK; i++) begin
            lane_per[i] = 0;
            lane_hi[i]  = 0;
            lane_c[i]   = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N_CLK; i++) begin
                if (lane_per[i] > 0) begin
                    mon_clk[i] = (lane_c[i] >= lane_per[i] - lane_hi[i]);
                    lane_c[i]  = (lane_c[i] + 1) % lane_per[i];
                end else begin
                    mon_clk[i] = 1'b0;
                end
            end
        end
    end

    // Result monitor: one line per completed transaction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n_done++;
                if (sb.size() == 0) begin
                    check_val("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("period", int'(period), e.period);
                    check_val("high_time", int'(high_time), e.high);
                    check_val("per_err", int'(per_err), e.per_err);
                    check_val("stuck", int'(stuck), e.stuck);
                    check_val("busy_at_done", int'(busy), 0);
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
                    check_val("duty_err", int'(duty_err), e.duty);
`endif
                    if (e.done_cyc >= 0) begin
                        check_val("done_latency", cyc, e.done_cyc);
                    end
                    $display("txn cyc=%0d period=%0d high=%0d per_err=%0b stuck=%0b",
                             cyc, period, high_time, per_err, stuck);
                end
            end
        end
    end

    task automatic lanes_off();
        for (int i = 0; i < N_CLK; i++) lane_per[i] = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic lane_on(input int sel, input int p, input int h);
        lane_c[sel]   = 0;
        lane_hi[sel]  = h;
        lane_per[sel] = p;
    endtask

    // Pulse start for one cycle; returns the cycle index of the sampling edge.
    task automatic pulse_start(output int s_cyc);
        start = 1'b1;
        s_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            check_val("wait_timeout", 1, 0);
            sb.delete();
        end
    endtask

    // Full measurement: expectation comes from the lane waveform and the limits.
    task automatic run_meas(input int sel, input int p, input int h,
                            input int pmin, input int pmax, input int hmin, input int hmax);
        exp_t e;
        int   s_cyc;
        lanes_off();
        mon_sel = SW'(sel);
        per_min = CW'(pmin);
        per_max = CW'(pmax);
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
        hi_min  = CW'(hmin);
        hi_max  = CW'(hmax);
`endif
        if (p > 0) lane_on(sel, p, h);
        if (p == 0 || p > TIMEOUT) begin
            e.period = 0; e.high = 0; e.per_err = 0; e.stuck = 1; e.duty = 0;
        end else begin
            e.period  = p;
            e.high    = h;
            e.per_err = (p < pmin || p > pmax) ? 1 : 0;
            e.stuck   = 0;
            e.duty    = (h < hmin || h > hmax) ? 1 : 0;
        end
        e.done_cyc = -1;
        sb.push_back(e);
        pulse_start(s_cyc);
        if (p == 0) sb[sb.size()-1].done_cyc = s_cyc + TIMEOUT + 1;
        check_val("busy_after_start", int'(busy), 1);
        wait_idle(400);
    endtask

    initial begin
        exp_t e;
        int   s_cyc;
        int   done_before;
        rst_n   = 1'b0;
        start   = 1'b0;
        mon_sel = '0;
        per_min = '0;
        per_max = '0;
`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
        hi_min  = '0;
        hi_max  = '0;
`endif
        repeat (3) @(negedge clk);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_period", int'(period), 0);
        check_val("rst_high_time", int'(high_time), 0);
        check_val("rst_per_err", int'(per_err), 0);
        check_val("rst_stuck", int'(stuck), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal, out-of-range and inclusive-boundary periods.
        run_meas(3, 10, 5, 8, 12, 0, 65535);
        run_meas(0, 20, 10, 8, 12, 0, 65535);
        run_meas(7, 8, 4, 8, 12, 0, 65535);
        run_meas(12, 12, 6, 8, 12, 0, 65535);
        run_meas(13, 13, 6, 8, 12, 0, 65535);
        run_meas(11, 7, 3, 8, 12, 0, 65535);
        // Inverted limits flag every period.
        run_meas(31, 10, 5, 12, 8, 0, 65535);
        // Rise on the timeout count wins; one cycle longer times out in MEAS.
        run_meas(9, 64, 32, 8, 12, 0, 65535);
        run_meas(9, 65, 32, 8, 12, 0, 65535);
        // Dead lane times out in ARM with a fixed latency.
        run_meas(5, 0, 0, 8, 12, 0, 65535);

        // Dead lane again, with a start presented in the same cycle as done.
        lanes_off();
        mon_sel = SW'(4);
        per_min = CW'(8);
        per_max = CW'(12);
        e.period = 0; e.high = 0; e.per_err = 0; e.stuck = 1; e.duty = 0;
        e.done_cyc = -1;
        sb.push_back(e);
        pulse_start(s_cyc);
        sb[sb.size()-1].done_cyc = s_cyc + TIMEOUT + 1;
        while (cyc < s_cyc + TIMEOUT) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_val("start_at_done_ignored", int'(busy), 0);
        wait_idle(100);

        // Select and limits changed plus a second start mid-MEAS.
        lanes_off();
        done_before = n_done;
        mon_sel = SW'(3);
        per_min = CW'(8);
        per_max = CW'(12);
        lane_on(3, 10, 5);
        e.period = 10; e.high = 5; e.per_err = 0; e.stuck = 0; e.duty = 0;
        e.done_cyc = -1;
        sb.push_back(e);
        pulse_start(s_cyc);
        repeat (11) @(negedge clk);
        check_val("busy_mid_meas", int'(busy), 1);
        lane_on(0, 6, 3);
        mon_sel = SW'(0);
        per_min = CW'(100);
        per_max = CW'(200);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_idle(100);
        repeat (40) @(negedge clk);
        check_val("single_done", n_done - done_before, 1);

        // One-cycle reset in the middle of a measurement.
        lanes_off();
        mon_sel = SW'(3);
        per_min = CW'(8);
        per_max = CW'(12);
        lane_on(3, 10, 5);
        pulse_start(s_cyc);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_done", int'(done), 0);
        check_val("midrst_period", int'(period), 0);
        check_val("midrst_high_time", int'(high_time), 0);
        check_val("midrst_per_err", int'(per_err), 0);
        check_val("midrst_stuck", int'(stuck), 0);
        run_meas(6, 14, 7, 10, 16, 0, 65535);

`ifdef CLK_FREQ_MONITOR_DUTY_CHECK_EN
        run_meas(3, 10, 2, 8, 12, 4, 6);
        run_meas(3, 10, 5, 8, 12, 4, 6);
`endif

        repeat (5) @(negedge clk);
        check_val("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
